// File: rtl/gx_rst_pkg.sv
// gx_rst_pkg: shared state encodings and counter sizing for the transceiver reset sequencer
package gx_rst_pkg;
  typedef enum logic [1:0] {TX_ANA, TX_DIG, TX_RDY} tx_state_e;
  typedef enum logic [1:0] {RX_ANA, RX_LOCK, RX_RDY} rx_state_e;
  function automatic int cnt_w(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/gx_rx_rst_ch.sv
// gx_rx_rst_ch: one RX lane's reset FSM with CDR-lock synchronizer and stable counter
module gx_rx_rst_ch
  import gx_rst_pkg::*;
#(
  parameter int CW       = 5,
  parameter int ANA_CYC  = 8,
  parameter int LOCK_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic cal_busy_i,
  input  logic lock_i,
  input  logic go_i,
  input  logic drop_i,
  output logic stable_o,
  output logic abort_o,
  output logic ana_o,
  output logic dig_o,
  output logic rdy_o
);
  rx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [1:0] sync_q, sync_d;
  logic ana_q, ana_d, dig_q, dig_d, rdy_q, rdy_d;
  logic lock_s, busy_abort;
  assign lock_s     = sync_q[1];
  assign busy_abort = state_q != RX_ANA && cal_busy_i;
  // stable_o is true on the cycle whose edge completes LOCK_CYC consecutive locked cycles
  assign stable_o   = state_q == RX_LOCK && lock_s && cnt_q >= CW'(LOCK_CYC - 1);
  assign abort_o    = busy_abort || (state_q == RX_RDY && !lock_s);
  assign ana_o      = ana_q;
  assign dig_o      = dig_q;
  assign rdy_o      = rdy_q;
  always_comb begin
    sync_d  = {sync_q[0], lock_i};
    cnt_inc = cnt_q >= CW'(state_q == RX_ANA ? ANA_CYC : LOCK_CYC) ? cnt_q : cnt_q + 1'b1;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (busy_abort) begin
      state_d = RX_ANA;
      cnt_d   = '0;
    end else if (state_q == RX_ANA) begin
      cnt_d = cal_busy_i ? '0 : cnt_inc;
      if (!cal_busy_i && cnt_q >= CW'(ANA_CYC - 1)) begin
        state_d = RX_LOCK;
        cnt_d   = '0;
      end
    end else if (state_q == RX_LOCK) begin
      cnt_d = lock_s && !drop_i ? cnt_inc : '0;
      if (go_i && !drop_i) begin
        state_d = RX_RDY;
        cnt_d   = '0;
      end
    end else if (!lock_s || drop_i) begin
      state_d = RX_LOCK;
      cnt_d   = '0;
    end
    ana_d = state_d == RX_ANA;
    dig_d = state_d != RX_RDY;
    rdy_d = state_d == RX_RDY;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RX_ANA;
      cnt_q   <= '0;
      sync_q  <= '0;
      ana_q   <= 1'b1;
      dig_q   <= 1'b1;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
      ana_q   <= ana_d;
      dig_q   <= dig_d;
      rdy_q   <= rdy_d;
    end
  end
endmodule

// File: rtl/gx_reset_seq.sv
// gx_reset_seq: transceiver reset sequencer with shared TX FSM and per-lane (optionally bonded) RX FSMs
module gx_reset_seq
  import gx_rst_pkg::*;
#(
  parameter int CH_N       = 1,
  parameter int BONDED     = 0,
  parameter int TX_ANA_CYC = 8,
  parameter int RX_ANA_CYC = 8,
  parameter int DIG_CYC    = 4,
  parameter int LOCK_CYC   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pll_locked_i,
  input  logic [CH_N-1:0] tx_cal_busy_i,
  input  logic [CH_N-1:0] rx_cal_busy_i,
  input  logic [CH_N-1:0] rx_is_lockedtodata_i,
  output logic [CH_N-1:0] tx_analogreset_o,
  output logic [CH_N-1:0] tx_digitalreset_o,
  output logic [CH_N-1:0] rx_analogreset_o,
  output logic [CH_N-1:0] rx_digitalreset_o,
  output logic            tx_ready_o,
  output logic [CH_N-1:0] rx_ready_o
);
  localparam int CW = cnt_w(TX_ANA_CYC, RX_ANA_CYC, DIG_CYC, LOCK_CYC);
  tx_state_e tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, tx_lim;
  logic tx_ana_q, tx_ana_d, tx_dig_q, tx_dig_d, tx_rdy_q, tx_rdy_d;
  logic [CH_N-1:0] stable, abort, go, drop;
  always_comb begin
    tx_lim     = tx_state_q == TX_ANA ? CW'(TX_ANA_CYC) : CW'(DIG_CYC);
    tx_cnt_d   = tx_cnt_q >= tx_lim ? tx_cnt_q : tx_cnt_q + 1'b1;
    tx_state_d = tx_state_q;
    if (tx_state_q != TX_ANA && !pll_locked_i) begin
      tx_state_d = TX_ANA;
      tx_cnt_d   = '0;
    end else if (tx_state_q == TX_ANA && tx_cnt_q >= CW'(TX_ANA_CYC - 1) && pll_locked_i && !(|tx_cal_busy_i)) begin
      tx_state_d = TX_DIG;
      tx_cnt_d   = '0;
    end else if (tx_state_q == TX_DIG && tx_cnt_q >= CW'(DIG_CYC - 1)) begin
      tx_state_d = TX_RDY;
      tx_cnt_d   = '0;
    end
    tx_ana_d = tx_state_d == TX_ANA;
    tx_dig_d = tx_state_d != TX_RDY;
    tx_rdy_d = tx_state_d == TX_RDY;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= TX_ANA;
      tx_cnt_q   <= '0;
      tx_ana_q   <= 1'b1;
      tx_dig_q   <= 1'b1;
      tx_rdy_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_ana_q   <= tx_ana_d;
      tx_dig_q   <= tx_dig_d;
      tx_rdy_q   <= tx_rdy_d;
    end
  end
  // Bonded lanes release together and fall back together on any lane's lock loss or recalibration
  assign go   = BONDED != 0 ? {CH_N{&stable}} : stable;
  assign drop = {CH_N{BONDED != 0 && |abort}};
  assign tx_analogreset_o  = {CH_N{tx_ana_q}};
  assign tx_digitalreset_o = {CH_N{tx_dig_q}};
  assign tx_ready_o        = tx_rdy_q;
  for (genvar c = 0; c < CH_N; c++) begin : g_ch
    gx_rx_rst_ch #(
      .CW      (CW),
      .ANA_CYC (RX_ANA_CYC),
      .LOCK_CYC(LOCK_CYC)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .cal_busy_i(rx_cal_busy_i[c]),
      .lock_i    (rx_is_lockedtodata_i[c]),
      .go_i      (go[c]),
      .drop_i    (drop[c]),
      .stable_o  (stable[c]),
      .abort_o   (abort[c]),
      .ana_o     (rx_analogreset_o[c]),
      .dig_o     (rx_digitalreset_o[c]),
      .rdy_o     (rx_ready_o[c])
    );
  end
endmodule

// File: tb/tb_gx_reset_seq.sv
// tb_gx_reset_seq: directed scenarios with a cycle-stamped expected-output scoreboard
module tb_gx_reset_seq;
  typedef struct {
    int          cyc;
    logic [20:0] val;
    string       nm;
  } exp_t;
  logic clk = 0;
  logic [2:0] rst = 3'b111;
  logic pll = 1;
  logic [3:0] tx_busy = 0, rx_busy = 0, lock = 0;
  logic a_txa, a_txd, a_rxa, a_rxd, a_txr, a_rxr;
  logic [3:0] b_txa, b_txd, b_rxa, b_rxd, b_rxr, c_txa, c_txd, c_rxa, c_rxd, c_rxr;
  logic b_txr, c_txr;
  logic [20:0] obs, prev = '0;
  logic [3:0] m_txa, m_txd, m_rxa, m_rxd, m_rxr, chm;
  logic m_txr;
  int sel = 0, cyc = 0, r = 0, n_run = 0, n_fail = 0;
  logic mon_en = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gx_reset_seq u_a (
    .clk(clk), .reset(rst[0]), .pll_locked_i(pll), .tx_cal_busy_i(tx_busy[0:0]),
    .rx_cal_busy_i(rx_busy[0:0]), .rx_is_lockedtodata_i(lock[0:0]),
    .tx_analogreset_o(a_txa), .tx_digitalreset_o(a_txd), .rx_analogreset_o(a_rxa),
    .rx_digitalreset_o(a_rxd), .tx_ready_o(a_txr), .rx_ready_o(a_rxr));
  gx_reset_seq #(.CH_N(4), .BONDED(1)) u_b (
    .clk(clk), .reset(rst[1]), .pll_locked_i(pll), .tx_cal_busy_i(tx_busy),
    .rx_cal_busy_i(rx_busy), .rx_is_lockedtodata_i(lock),
    .tx_analogreset_o(b_txa), .tx_digitalreset_o(b_txd), .rx_analogreset_o(b_rxa),
    .rx_digitalreset_o(b_rxd), .tx_ready_o(b_txr), .rx_ready_o(b_rxr));
  gx_reset_seq #(.CH_N(4), .BONDED(0)) u_c (
    .clk(clk), .reset(rst[2]), .pll_locked_i(pll), .tx_cal_busy_i(tx_busy),
    .rx_cal_busy_i(rx_busy), .rx_is_lockedtodata_i(lock),
    .tx_analogreset_o(c_txa), .tx_digitalreset_o(c_txd), .rx_analogreset_o(c_rxa),
    .rx_digitalreset_o(c_rxd), .tx_ready_o(c_txr), .rx_ready_o(c_rxr));

  always_comb begin
    obs = '0;
    if (sel == 0) obs = {3'b0, a_txa, 3'b0, a_txd, 3'b0, a_rxa, 3'b0, a_rxd, a_txr, 3'b0, a_rxr};
    else if (sel == 1) obs = {b_txa, b_txd, b_rxa, b_rxd, b_txr, b_rxr};
    else obs = {c_txa, c_txd, c_rxa, c_rxd, c_txr, c_rxr};
  end

  // Any output change must coincide with a scheduled expectation
  always @(negedge clk) begin
    if (mon_en) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        exp_t e;
        e = sb.pop_front();
        n_run++;
        n_fail++;
        $display("FAIL %s: check at cyc %0d skipped (now %0d), want %h", e.nm, e.cyc, cyc, e.val);
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        exp_t e;
        e = sb.pop_front();
        n_run++;
        if (obs !== e.val) begin
          n_fail++;
          $display("FAIL %s @cyc %0d: got %h want %h", e.nm, cyc, obs, e.val);
        end
      end else if (obs !== prev) begin
        n_run++;
        n_fail++;
        $display("FAIL unexpected_change @cyc %0d: got %h was %h", cyc, obs, prev);
      end
    end
    prev = obs;
  end

  task automatic ev(input string nm, input int n);
    exp_t e;
    e.cyc = n;
    e.val = {m_txa, m_txd, m_rxa, m_rxd, m_txr, m_rxr};
    e.nm  = nm;
    sb.push_back(e);
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic start(input int s);
    @(negedge clk);
    mon_en = 0;
    sel    = s;
    rst[s] = 1'b1;
    repeat (3) @(negedge clk);
    chm   = s == 0 ? 4'b0001 : 4'b1111;
    m_txa = chm;
    m_txd = chm;
    m_rxa = chm;
    m_rxd = chm;
    m_txr = 0;
    m_rxr = 0;
    mon_en = 1;
    ev("reset_state", cyc + 1);
    @(negedge clk);
    rst[s] = 1'b0;
    r = cyc;
  endtask

  initial begin
    // CH_N=1 power-up: CDR locks once RX analog reset releases
    lock = 0;
    start(0);
    m_txa = 0; m_rxa = 0;             ev("s1_ana_rel", r + 8);
    m_txd = 0; m_txr = 1;             ev("s1_tx_rdy", r + 12);
    m_rxd = 0; m_rxr = 1;             ev("s1_rx_rdy", r + 26);
    wait_to(r + 8);
    lock = 4'hF;
    wait_to(r + 30);
    // tx_cal_busy held for 20 cycles, lock held throughout
    tx_busy = 4'hF;
    start(0);
    m_rxa = 0;                        ev("s2_rx_ana_rel", r + 8);
                                      ev("s2_busy_hold", r + 20);
    m_txa = 0;                        ev("s2_tx_ana_rel", r + 21);
    m_rxd = 0; m_rxr = 1;             ev("s2_rx_rdy", r + 24);
    m_txd = 0; m_txr = 1;             ev("s2_tx_rdy", r + 25);
    wait_to(r + 20);
    tx_busy = 0;
    // PLL loss in TX_RDY replays TX only
    wait_to(r + 28);
    m_txa = 1; m_txd = 1; m_txr = 0;  ev("s5_pll_drop", r + 31);
                                      ev("s5_rx_hold", r + 36);
    m_txa = 0;                        ev("s5_tx_ana_rel", r + 39);
    m_txd = 0; m_txr = 1;             ev("s5_tx_rdy", r + 43);
    wait_to(r + 30);
    pll = 0;
    wait_to(r + 33);
    pll = 1;
    wait_to(r + 48);
    // Reset pulsed while RX waits in RX_LOCK
    lock = 0;
    start(0);
    m_txa = 0; m_rxa = 0;             ev("s6_ana_rel", r + 8);
    m_txd = 0; m_txr = 1;             ev("s6_tx_rdy", r + 12);
                                      ev("s6_in_lock", r + 14);
    m_txa = 1; m_txd = 1; m_rxa = 1; m_txr = 0;
                                      ev("s6_reset_mid", r + 16);
                                      ev("s6_reset_hold", r + 19);
    wait_to(r + 15);
    rst[0] = 1'b1;
    wait_to(r + 21);
    // CH_N=4 bonded, lane 2 locks 30 cycles late, then lane 3 glitches
    lock = 0;
    start(1);
    m_txa = 0; m_rxa = 0;             ev("s3_ana_rel", r + 8);
    m_txd = 0; m_txr = 1;             ev("s3_tx_rdy", r + 12);
                                      ev("s3_wait_lane2", r + 55);
    m_rxd = 0; m_rxr = 4'hF;          ev("s3_bond_rdy", r + 56);
    m_rxd = 4'hF; m_rxr = 0;          ev("s3_bond_drop", r + 63);
    m_rxd = 0; m_rxr = 4'hF;          ev("s3_bond_rerdy", r + 79);
    wait_to(r + 8);
    lock = 4'b1011;
    wait_to(r + 38);
    lock = 4'hF;
    wait_to(r + 60);
    lock = 4'b0111;
    wait_to(r + 61);
    lock = 4'hF;
    wait_to(r + 84);
    // CH_N=4 unbonded, one-cycle glitch on lane 1
    lock = 0;
    start(2);
    m_txa = 0; m_rxa = 0;             ev("s4_ana_rel", r + 8);
    m_txd = 0; m_txr = 1;             ev("s4_tx_rdy", r + 12);
    m_rxd = 0; m_rxr = 4'hF;          ev("s4_rx_rdy", r + 26);
    m_rxd = 4'b0010; m_rxr = 4'b1101; ev("s4_lane1_drop", r + 33);
                                      ev("s4_lane1_wait", r + 40);
    m_rxd = 0; m_rxr = 4'hF;          ev("s4_lane1_back", r + 49);
    wait_to(r + 8);
    lock = 4'hF;
    wait_to(r + 30);
    lock = 4'b1101;
    wait_to(r + 31);
    lock = 4'hF;
    wait_to(r + 54);
    mon_en = 0;
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_run++;
      n_fail++;
      $display("FAIL %s: never checked (cyc %0d), want %h", e.nm, e.cyc, e.val);
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
